des_iterative_engine: RTL and testbench
=======================================

// Module: des_iterative_engine
// PURPOSE
//  Sequencer for the DES round datapath: accepts one 64-bit block, key and mode per transaction, runs the 16
//  Feistel rounds over UNROLL round instances per clock, and derives each round's subkey on the fly
//  (encrypt: left rotations; decrypt: right rotations, subkeys in reverse order). Sits between a
//  valid/ready block source and sink; replaces the fully-unrolled combinational cipher where area matters.
// PARAMETERS
//  UNROLL  1  rounds evaluated per clock; legal values 1,2,4 (other values: $error at elaboration)
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   synchronous active-low reset
//  in_valid   in   1   in_block/in_key/in_decrypt valid
//  in_ready   out  1   engine can accept (high only in IDLE)
//  in_block   in   64  plaintext (encrypt) or ciphertext (decrypt), bit 63 = DES bit 1
//  in_key     in   64  DES key incl. parity bits (parity ignored)
//  in_decrypt in   1   0 = encrypt, 1 = decrypt
//  out_valid  out  1   out_block valid; held until out_ready
//  out_ready  in   1   sink accepts out_block
//  out_block  out  64  result, same bit ordering as in_block
//  busy       out  1   high in RUN or DONE
// BEHAVIOUR
//  Reset (rst_n=0 at posedge, any state): state=IDLE, in_ready=1 after reset release, out_valid=0,
//   busy=0, out_block=0, round counter=0, L/R/C/D=0. Reset mid-RUN/DONE discards the block; no output.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&&in_ready: L,R <= IP(in_block); C,D <= PC1(in_key); mode latched;
//   cnt <= 0; -> RUN. Inputs sampled only on that edge; later input changes have no effect.
//  RUN: each clock applies UNROLL rounds r=cnt..cnt+UNROLL-1 (0-based); cnt += UNROLL.
//   Shift table SHIFTS[r] = 1 for r in {0,1,8,15}, else 2.
//   Encrypt round r: C,D rotl by SHIFTS[r], then K=PC2(C,D).
//   Decrypt round r: K=PC2(C,D) first, then C,D rotr by SHIFTS[15-r] (r=0 uses unrotated PC1 = K16).
//   Round: L' = R; R' = L ^ P(S(E(R) ^ K)). After final round (cnt reaches 16) -> DONE,
//   out_block <= FP({R,L}) (swap undone), out_valid=1 on the same edge.
//  Latency: accept edge to out_valid high = 16/UNROLL + 1 rising edges (17 / 9 / 5).
//  DONE: out_valid=1, out_block stable until out_valid&&out_ready edge -> IDLE, out_valid=0.
//   in_ready=0 in RUN and DONE; in_valid ignored there (source must hold it; not dropped, not queued).
//  Back-to-back: next accept earliest the edge after out handshake (in_ready rises in IDLE) ->
//   throughput one block per 16/UNROLL+2 cycles with out_ready tied high.
//  cnt is 5 bits, never wraps past 16; C,D rotations are mod 28, after 16 rounds C,D == PC1 state again
//   (both modes) -- checked by assertion in DONE.
//  out_ready high while not out_valid: no effect. X on in_* outside accept edge: no effect.
// STRUCTURE
//  des_pkg: IP, FP, E, P, PC1, PC2 index tables (1-based DES numbering), S1..S8 as 4x16 nibble
//   constants, SHIFTS[0:15], state enum {IDLE,RUN,DONE}, functions permute/ip/fp/pc1/pc2.
//  Sub-module des_round (combinational): in L,R(32), K(48) -> out L',R'; instantiated UNROLL times
//   in a chain inside the engine; key-schedule rotation logic stays in the engine.
// TESTING
//  1 Encrypt key 133457799BBCDFF1, block 0123456789ABCDEF -> 85E813540F0AB405 after 17 cycles (UNROLL=1).
//  2 Decrypt same key, block 85E813540F0AB405 -> 0123456789ABCDEF; zero key/zero block encrypt
//    -> 8CA64DE9C1B123A7.
//  3 out_ready held low 10 cycles in DONE: out_block/out_valid stable, in_ready=0, in_valid ignored;
//    release -> IDLE, next block accepted one cycle later.
//  4 rst_n=0 at RUN cycle 7: next cycle in_ready=1, out_valid=0, busy=0; subsequent vector 1 correct.
//  5 UNROLL=2 and 4: vectors 1-2 give same results at latency 9 and 5; 1000 random key/block pairs
//    checked against reference model, encrypt then decrypt round-trips to original.
//  6 Key parity bits flipped (key 123456789ABCDEF0 vs 133457799BBCDFF1 parity-only variants) -> identical output.

Source files
------------

// File: rtl/des_pkg.sv
// DES constant tables and permutation helpers shared by the iterative engine.
// All tables use DES bit numbering: bit 1 is the MSB of the vector.
package des_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StDone} des_state_e;

   localparam int unsigned IpTbl [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

   localparam int unsigned FpTbl [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};

   localparam int unsigned ETbl [48] = '{
      32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31,
      32, 1};

   localparam int unsigned PTbl [32] = '{
      16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
      2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

   localparam int unsigned Pc1Tbl [56] = '{
      57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18, 10, 2, 59, 51, 43, 35, 27, 19, 11, 3,
      60, 52, 44, 36, 63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22, 14, 6, 61, 53, 45,
      37, 29, 21, 13, 5, 28, 20, 12, 4};

   localparam int unsigned Pc2Tbl [48] = '{
      14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36,
      29, 32};

   // Each S-box row packs its 16 nibbles with column 0 in the top nibble.
   localparam logic [63:0] SBoxTbl [8][4] = '{
      '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
      '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
      '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
      '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
      '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
      '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
      '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
      '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}};

   localparam logic [1:0] ShiftTbl [16] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

   function automatic logic [63:0] ip(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 64; i++) y[63-i] = x[64-IpTbl[i]];
      return y;
   endfunction

   function automatic logic [63:0] fp(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 64; i++) y[63-i] = x[64-FpTbl[i]];
      return y;
   endfunction

   // Parity bits (8, 16, ..., 64) are never referenced by the table.
   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] y;
      for (int i = 0; i < 56; i++) y[55-i] = k[64-Pc1Tbl[i]];
      return y;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] y;
      for (int i = 0; i < 48; i++) y[47-i] = cd[56-Pc2Tbl[i]];
      return y;
   endfunction

   function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
      return (n == 2'd1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
      return (n == 2'd1) ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
   endfunction

   function automatic logic [31:0] feistel_f(input logic [31:0] r, input logic [47:0] k);
      logic [47:0] x;
      logic [31:0] s;
      logic [31:0] y;
      logic [5:0]  b;
      logic [63:0] row;
      for (int i = 0; i < 48; i++) x[47-i] = r[32-ETbl[i]];
      x = x ^ k;
      for (int j = 0; j < 8; j++) begin
         b   = x[47-6*j -: 6];
         row = SBoxTbl[j][{b[5], b[0]}];
         s[31-4*j -: 4] = row[63-4*int'(b[4:1]) -: 4];
      end
      for (int i = 0; i < 32; i++) y[31-i] = s[32-PTbl[i]];
      return y;
   endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES Feistel round: L' = R, R' = L ^ f(R, K).
module des_round
   import des_pkg::*;
(
   input  logic [31:0] l_i,
   input  logic [31:0] r_i,
   input  logic [47:0] k_i,
   output logic [31:0] l_o,
   output logic [31:0] r_o
);

   assign l_o = r_i;
   assign r_o = l_i ^ feistel_f(r_i, k_i);

endmodule

// File: rtl/des_iterative_engine.sv
// Iterative DES engine: UNROLL Feistel rounds per clock with an on-the-fly key schedule,
// valid/ready block handshake on both sides.
module des_iterative_engine
   import des_pkg::*;
#(
   parameter int unsigned UNROLL = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_block,
   input  logic [63:0] in_key,
   input  logic        in_decrypt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_block,
   output logic        busy
);

   if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
      $error("des_iterative_engine: UNROLL must be 1, 2 or 4");
   end

   des_state_e  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] l_q, l_d, r_q, r_d;
   logic [27:0] c_q, c_d, d_q, d_d;
   logic        dec_q, dec_d;
   logic [63:0] out_q, out_d;

   // Encrypt rotates before deriving the subkey; decrypt derives first, then rotates right.
   for (genvar u = 0; u < UNROLL; u++) begin : g_lane
      logic [3:0]  rnd;
      logic [27:0] c_in, d_in, c_out, d_out;
      logic [31:0] l_in, r_in, l_out, r_out;
      logic [47:0] subkey;

      if (u == 0) begin : g_first
         assign c_in = c_q;
         assign d_in = d_q;
         assign l_in = l_q;
         assign r_in = r_q;
      end else begin : g_next
         assign c_in = g_lane[u-1].c_out;
         assign d_in = g_lane[u-1].d_out;
         assign l_in = g_lane[u-1].l_out;
         assign r_in = g_lane[u-1].r_out;
      end

      assign rnd    = cnt_q[3:0] + 4'(u);
      assign c_out  = dec_q ? rotr28(c_in, ShiftTbl[4'd15 - rnd]) : rotl28(c_in, ShiftTbl[rnd]);
      assign d_out  = dec_q ? rotr28(d_in, ShiftTbl[4'd15 - rnd]) : rotl28(d_in, ShiftTbl[rnd]);
      assign subkey = dec_q ? pc2({c_in, d_in}) : pc2({c_out, d_out});

      des_round u_round (
         .l_i (l_in),
         .r_i (r_in),
         .k_i (subkey),
         .l_o (l_out),
         .r_o (r_out)
      );
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      l_d     = l_q;
      r_d     = r_q;
      c_d     = c_q;
      d_d     = d_q;
      dec_d   = dec_q;
      out_d   = out_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               {l_d, r_d} = ip(in_block);
               {c_d, d_d} = pc1(in_key);
               dec_d      = in_decrypt;
               cnt_d      = 5'd0;
               state_d    = StRun;
            end
         end
         StRun: begin
            l_d   = g_lane[UNROLL-1].l_out;
            r_d   = g_lane[UNROLL-1].r_out;
            c_d   = g_lane[UNROLL-1].c_out;
            d_d   = g_lane[UNROLL-1].d_out;
            cnt_d = cnt_q + 5'(UNROLL);
            if (cnt_d == 5'd16) begin
               // Final swap is undone by presenting {R, L} to FP.
               out_d   = fp({g_lane[UNROLL-1].r_out, g_lane[UNROLL-1].l_out});
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 5'd0;
         l_q     <= 32'd0;
         r_q     <= 32'd0;
         c_q     <= 28'd0;
         d_q     <= 28'd0;
         dec_q   <= 1'b0;
         out_q   <= 64'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         l_q     <= l_d;
         r_q     <= r_d;
         c_q     <= c_d;
         d_q     <= d_d;
         dec_q   <= dec_d;
         out_q   <= out_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign out_block = out_q;

endmodule

// File: tb/tb_des_iterative_engine.sv
// Bench for des_iterative_engine: UNROLL=1,2,4 instances share stimulus and are checked
// every cycle against a textbook DES model with a precomputed key schedule.
module tb_des_iterative_engine;

   localparam int PT [32] = '{
      16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
      2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
   localparam int PC1T [56] = '{
      57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18, 10, 2, 59, 51, 43, 35, 27, 19, 11, 3,
      60, 52, 44, 36, 63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22, 14, 6, 61, 53, 45,
      37, 29, 21, 13, 5, 28, 20, 12, 4};
   localparam int PC2T [48] = '{
      14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36,
      29, 32};
   localparam logic [63:0] SB [32] = '{
      64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
      64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
      64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
      64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
      64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
      64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
      64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
      64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};
   localparam int LAT [3]    = '{16, 8, 4};
   localparam int LATLIT [3] = '{17, 9, 5};
   localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
   localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
   localparam logic [63:0] C1 = 64'h85E813540F0AB405;
   localparam logic [63:0] CZ = 64'h8CA64DE9C1B123A7;
   localparam logic [63:0] PAR = 64'h0101010101010101;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_decrypt, out_ready;
   logic [63:0] in_block, in_key;
   logic [2:0]  in_ready_w, out_valid_w, busy_w;
   logic [63:0] out_block_w [3];
   logic [55:0] cd_w [3];

   int          n_cmp = 0, n_bad = 0, cyc = 0;
   bit          chk_en = 0;
   bit   [2:0]  pending = '0;
   int          acc [3];
   logic [63:0] exp_blk [3];
   logic [55:0] exp_cd [3];
   logic [63:0] res_blk [3];
   int          lat_m [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      des_iterative_engine #(.UNROLL(1 << g)) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .in_valid   (in_valid),
         .in_ready   (in_ready_w[g]),
         .in_block   (in_block),
         .in_key     (in_key),
         .in_decrypt (in_decrypt),
         .out_valid  (out_valid_w[g]),
         .out_ready  (out_ready),
         .out_block  (out_block_w[g]),
         .busy       (busy_w[g])
      );
      assign cd_w[g] = {u_dut.c_q, u_dut.d_q};
   end

   task automatic chk(input string name, input int idx, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d] at cycle %0d: got %h want %h", name, idx, cyc, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int ip_src(input int i);
      int row = i / 8;
      return ((row < 4) ? 58 + 2 * row : 57 + 2 * (row - 4)) - 8 * (i % 8);
   endfunction

   function automatic logic [55:0] ref_pc1(input logic [63:0] k);
      logic [55:0] y;
      for (int i = 0; i < 56; i++) y[55-i] = k[64-PC1T[i]];
      return y;
   endfunction

   function automatic logic [31:0] ref_f(input logic [31:0] r, input logic [47:0] k);
      logic [47:0] x;
      logic [31:0] s, y;
      logic [5:0]  b;
      logic [63:0] line;
      int          src, col;
      for (int i = 0; i < 48; i++) begin
         src = ((4 * (i / 6) + (i % 6) + 31) % 32) + 1;
         x[47-i] = r[32-src];
      end
      x = x ^ k;
      for (int j = 0; j < 8; j++) begin
         b    = x[47-6*j -: 6];
         line = SB[4*j + {30'd0, b[5], b[0]}];
         col  = {28'd0, b[4:1]};
         s[31-4*j -: 4] = line[63-4*col -: 4];
      end
      for (int i = 0; i < 32; i++) y[31-i] = s[32-PT[i]];
      return y;
   endfunction

   function automatic logic [63:0] ref_des(input logic [63:0] key, input logic [63:0] blk,
                                           input logic dec);
      logic [47:0] ks [16];
      logic [55:0] cd, pre;
      logic [27:0] c, d;
      logic [63:0] x, y;
      logic [31:0] l, r, t;
      int          sh;
      cd = ref_pc1(key);
      c  = cd[55:28];
      d  = cd[27:0];
      for (int n = 0; n < 16; n++) begin
         sh = (n == 0 || n == 1 || n == 8 || n == 15) ? 1 : 2;
         for (int s = 0; s < sh; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
         pre = {c, d};
         for (int i = 0; i < 48; i++) ks[n][47-i] = pre[56-PC2T[i]];
      end
      for (int i = 0; i < 64; i++) x[63-i] = blk[64-ip_src(i)];
      l = x[63:32];
      r = x[31:0];
      for (int n = 0; n < 16; n++) begin
         t = l ^ ref_f(r, dec ? ks[15-n] : ks[n]);
         l = r;
         r = t;
      end
      x = {r, l};
      for (int i = 0; i < 64; i++) y[64-ip_src(i)] = x[63-i];
      return y;
   endfunction

   // Transaction-level view of each engine, advanced on every rising edge.
   initial begin
      forever begin
         @(posedge clk);
         for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
               pending[k] = 1'b0;
            end else if (pending[k]) begin
               if (cyc - acc[k] >= LAT[k] && out_ready) pending[k] = 1'b0;
            end else if (in_valid) begin
               pending[k] = 1'b1;
               acc[k]     = cyc + 1;
               exp_blk[k] = ref_des(in_key, in_block, in_decrypt);
               exp_cd[k]  = ref_pc1(in_key);
            end
         end
         cyc++;
      end
   end

   // Every-cycle compare of all three engines against the model.
   initial begin
      bit ev;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
               ev = pending[k] && (cyc - acc[k] >= LAT[k]);
               chk("out_valid", k, 64'(out_valid_w[k]), 64'(ev));
               chk("in_ready", k, 64'(in_ready_w[k]), 64'(!pending[k]));
               chk("busy", k, 64'(busy_w[k]), 64'(pending[k]));
               if (ev) begin
                  chk("out_block", k, out_block_w[k], exp_blk[k]);
                  chk("cd_restored", k, 64'(cd_w[k]), 64'(exp_cd[k]));
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_done(input int c0, input bit rnd_ready);
      bit [2:0] seen = '0;
      for (int n = 0; n < 200 && pending != 0; n++) begin
         for (int k = 0; k < 3; k++) begin
            if (!seen[k] && out_valid_w[k]) begin
               seen[k]    = 1'b1;
               lat_m[k]   = cyc - c0 + 1;
               res_blk[k] = out_block_w[k];
            end
         end
         if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      if (pending != 0) chk("timeout", 0, 64'(pending), 64'd0);
      for (int k = 0; k < 3; k++) begin
         chk("latency", k, seen[k] ? 64'(lat_m[k]) : 64'hFFFF, 64'(LATLIT[k]));
      end
      out_ready = 1'b1;
   endtask

   task automatic run_txn(input logic [63:0] key, input logic [63:0] blk, input logic dec,
                          input bit rnd_ready);
      @(negedge clk);
      in_key     = key;
      in_block   = blk;
      in_decrypt = dec;
      in_valid   = 1'b1;
      @(negedge clk);
      in_valid   = 1'b0;
      in_block   = {$urandom, $urandom};
      in_key     = {$urandom, $urandom};
      in_decrypt = 1'($urandom);
      wait_done(cyc, rnd_ready);
   endtask

   task automatic chk_all(input string name, input logic [63:0] exp);
      for (int k = 0; k < 3; k++) chk(name, k, res_blk[k], exp);
   endtask

   initial begin
      logic [63:0] key, blk, ct [3], ref0;
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] key, blk, ct0, ct1;
      int c0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_decrypt = 1'b0;
      in_block = '0; in_key = '0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("reset_out_block", k, out_block_w[k], 64'd0);
         chk("reset_state", k, {61'd0, in_ready_w[k], out_valid_w[k], busy_w[k]}, 64'b100);
      end
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Model pinned to known-answer vectors.
      chk("model_enc", 0, ref_des(K1, P1, 1'b0), C1);
      chk("model_dec", 0, ref_des(K1, C1, 1'b1), P1);
      chk("model_zero", 0, ref_des(64'd0, 64'd0, 1'b0), CZ);

      run_txn(K1, P1, 1'b0, 1'b0);  chk_all("vec1_enc", C1);
      run_txn(K1, C1, 1'b1, 1'b0);  chk_all("vec2_dec", P1);
      run_txn(64'd0, 64'd0, 1'b0, 1'b0);  chk_all("vec_zero", CZ);
      run_txn(K1 ^ PAR, P1, 1'b0, 1'b0);  chk_all("parity_k1", C1);

      key = 64'h123456789ABCDEF0;
      run_txn(key, P1, 1'b0, 1'b0);
      ct0 = res_blk[0];
      run_txn(key ^ PAR, P1, 1'b0, 1'b0);
      chk_all("parity_k2", ct0);

      // Back-pressure in DONE with a pending input that must wait.
      @(negedge clk);
      out_ready = 1'b0; in_key = K1; in_block = P1; in_decrypt = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (16) @(negedge clk);
      in_block = C1; in_decrypt = 1'b1; in_valid = 1'b1;
      repeat (10) @(negedge clk);
      chk("hold_valid", 0, 64'(out_valid_w), 64'b111);
      chk("hold_in_ready", 0, 64'(in_ready_w), 64'b000);
      for (int k = 0; k < 3; k++) chk("hold_block", k, out_block_w[k], C1);
      out_ready = 1'b1;
      @(negedge clk);
      chk("release_idle", 0, 64'(in_ready_w), 64'b111);
      @(negedge clk);
      chk("accept_next", 0, 64'(busy_w), 64'b111);
      in_valid = 1'b0;
      c0 = cyc;
      wait_done(c0, 1'b0);
      chk_all("after_hold_dec", P1);

      // Reset in the middle of a run.
      @(negedge clk);
      in_key = K1; in_block = P1; in_decrypt = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_in_ready", 0, 64'(in_ready_w), 64'b111);
      chk("rst_out_valid", 0, 64'(out_valid_w), 64'b000);
      chk("rst_busy", 0, 64'(busy_w), 64'b000);
      for (int k = 0; k < 3; k++) chk("rst_out_block", k, out_block_w[k], 64'd0);
      run_txn(K1, P1, 1'b0, 1'b0);  chk_all("post_rst_vec1", C1);

      // Random pairs with random out_ready, encrypt then decrypt round trip.
      for (int n = 0; n < 1000; n++) begin
         key = {$urandom, $urandom};
         blk = {$urandom, $urandom};
         run_txn(key, blk, 1'b0, 1'b1);
         ct0 = res_blk[0];
         ct1 = res_blk[2];
         chk("rnd_unroll_agree", n, ct1, ct0);
         run_txn(key, ct0, 1'b1, 1'b1);
         chk_all("rnd_roundtrip", blk);
      end

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
